// File: rtl/sort_stream_pkg.sv
// rtl/sort_stream_pkg.sv - shared FSM encodings and counter sizing for sort_stream
package sort_stream_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Width of a counter that must index 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// rtl/sort_cmp_swap.sv - combinational compare-exchange of one adjacent pair
module sort_cmp_swap #(
  parameter int WIDTH   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic [WIDTH-1:0] a_lo,
  input  logic [WIDTH-1:0] a_hi,
  output logic [WIDTH-1:0] y_lo,
  output logic [WIDTH-1:0] y_hi
);

  logic swap;

  // Swap only on strict inequality so equal values keep their places.
  always_comb begin
    swap = DESCEND ? (a_lo < a_hi) : (a_lo > a_hi);
    y_lo = swap ? a_hi : a_lo;
    y_hi = swap ? a_lo : a_hi;
  end

endmodule

// File: rtl/sort_stream.sv
// rtl/sort_stream.sv - serial-in, odd-even transposition sort, serial-out
module sort_stream
  import sort_stream_pkg::*;
#(
  parameter int NUM_VALS = 8,
  parameter int WIDTH    = 4,
  parameter bit DESCEND  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = cnt_width(NUM_VALS);
  localparam logic [CW-1:0] LAST = CW'(NUM_VALS - 1);

  state_e           state_q, state_d;
  // One counter serves as load index, pass number and drain index; it is
  // cleared on every state change so each state sees it start at zero.
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [NUM_VALS];
  logic [WIDTH-1:0] mem_d [NUM_VALS];

  // Buffer contents after an even pass (pairs 0-1, 2-3, ...) and after an
  // odd pass (pairs 1-2, 3-4, ...); elements outside any pair pass through.
  logic [WIDTH-1:0] even_v [NUM_VALS];
  logic [WIDTH-1:0] odd_v  [NUM_VALS];

  for (genvar k = 0; k < NUM_VALS / 2; k++) begin : g_even
    sort_cmp_swap #(.WIDTH(WIDTH), .DESCEND(DESCEND)) u_cmp (
      .a_lo (mem_q[2*k]),
      .a_hi (mem_q[2*k+1]),
      .y_lo (even_v[2*k]),
      .y_hi (even_v[2*k+1])
    );
  end

  if ((NUM_VALS % 2) == 1) begin : g_even_tail
    assign even_v[NUM_VALS-1] = mem_q[NUM_VALS-1];
  end

  assign odd_v[0] = mem_q[0];

  for (genvar k = 0; k < (NUM_VALS - 1) / 2; k++) begin : g_odd
    sort_cmp_swap #(.WIDTH(WIDTH), .DESCEND(DESCEND)) u_cmp (
      .a_lo (mem_q[2*k+1]),
      .a_hi (mem_q[2*k+2]),
      .y_lo (odd_v[2*k+1]),
      .y_hi (odd_v[2*k+2])
    );
  end

  if ((NUM_VALS % 2) == 0) begin : g_odd_tail
    assign odd_v[NUM_VALS-1] = mem_q[NUM_VALS-1];
  end

  // Next-state, counter, buffer and handshake outputs for LOAD/SORT/DRAIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;

    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_d[cnt_q] = in_data;
          if (cnt_q == LAST) begin
            state_d = ST_SORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_SORT: begin
        busy  = 1'b1;
        mem_d = cnt_q[0] ? odd_v : even_v;
        if (cnt_q == LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_q[cnt_q];
        out_last  = (cnt_q == LAST);
        if (out_ready) begin
          if (cnt_q == LAST) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and buffer registers; reset discards any partial batch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_VALS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_sort_stream.sv
// tb/tb_sort_stream.sv - self-checking bench for sort_stream (ascending and descending)
module tb_sort_stream;

  localparam int NV = 8;
  localparam int W  = 4;

  typedef logic [W-1:0] arr_t [NV];
  typedef struct {
    arr_t in_v;
    arr_t exp_v;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         out_ready;
  logic         in_ready_a, out_valid_a, out_last_a, busy_a;
  logic         in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [W-1:0] out_data_a, out_data_d;

  int tests = 0;
  int fails = 0;
  vec_t tbl [6];

  always #5 clk = ~clk;

  sort_stream #(.NUM_VALS(NV), .WIDTH(W), .DESCEND(1'b0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .out_data  (out_data_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_last  (out_last_a),
    .busy      (busy_a)
  );

  sort_stream #(.NUM_VALS(NV), .WIDTH(W), .DESCEND(1'b1)) dut_d (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_d),
    .out_data  (out_data_d),
    .out_valid (out_valid_d),
    .out_ready (out_ready),
    .out_last  (out_last_d),
    .busy      (busy_d)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_in_ready"},  {30'd0, in_ready_a,  in_ready_d},  32'd3);
    check({nm, "_out_valid"}, {30'd0, out_valid_a, out_valid_d}, 32'd0);
    check({nm, "_out_last"},  {30'd0, out_last_a,  out_last_d},  32'd0);
    check({nm, "_busy"},      {30'd0, busy_a,      busy_d},      32'd0);
  endtask

  task automatic feed(input arr_t v, input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      in_data  = v[i];
      in_valid = 1'b1;
      check("in_ready_load", {31'd0, in_ready_a & in_ready_d}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = hold;
  endtask

  task automatic wait_sort(input bit noise);
    int lat = 0;
    bit ok  = 1'b1;
    while (out_valid_a !== 1'b1 && lat < 30) begin
      if (in_ready_a || in_ready_d || !busy_a || !busy_d || out_valid_d) ok = 1'b0;
      if (noise) in_data = W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("sort_latency", lat, NV);
    check("sort_phase_flags", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain(input arr_t e, input int n, input bit rnd, input bit noise);
    for (int j = 0; j < n; j++) begin
      int  stalls = 0;
      bit  done   = 1'b0;
      while (!done) begin
        out_ready = (rnd && stalls < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (noise) in_data = W'($urandom);
        check("out_valid",  {30'd0, out_valid_a, out_valid_d}, 32'd3);
        check("asc_data",   out_data_a, e[j]);
        check("desc_data",  out_data_d, e[NV-1-j]);
        check("asc_last",   out_last_a, (j == NV-1));
        check("desc_last",  out_last_d, (j == NV-1));
        check("drain_flags", {30'd0, in_ready_a | in_ready_d, busy_a & busy_d}, 32'd1);
        @(posedge clk); #1;
        if (out_ready) done = 1'b1;
        else stalls++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic run_batch(input vec_t v, input bit rnd);
    feed(v.in_v, NV, 1'b0);
    wait_sort(1'b0);
    drain(v.exp_v, NV, rnd, 1'b0);
    check_idle("post_drain");
  endtask

  task automatic reset_pulse(input string nm);
    rst = 1'b1;
    #1;
    check_idle(nm);
    check({nm, "_out_data"}, {24'd0, out_data_a, out_data_d}, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0].in_v = '{4'd3, 4'd7, 4'd1, 4'd0, 4'd15, 4'd8, 4'd8, 4'd2};
    tbl[0].exp_v = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd8, 4'd15};
    tbl[1].in_v = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    tbl[1].exp_v = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    tbl[2].in_v = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    tbl[2].exp_v = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    tbl[3].in_v = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    tbl[3].exp_v = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    tbl[4].in_v = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd15, 4'd0, 4'd15, 4'd0};
    tbl[4].exp_v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15};
    tbl[5].in_v = '{4'd9, 4'd4, 4'd12, 4'd4, 4'd1, 4'd14, 4'd6, 4'd10};
    tbl[5].exp_v = '{4'd1, 4'd4, 4'd4, 4'd6, 4'd9, 4'd10, 4'd12, 4'd14};

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    check_idle("reset");
    check("reset_out_data", {24'd0, out_data_a, out_data_d}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table batches back to back with out_ready held high.
    for (int t = 0; t < 6; t++) begin
      run_batch(tbl[t], 1'b0);
    end

    // Drain with out_ready toggling randomly.
    run_batch(tbl[0], 1'b1);
    run_batch(tbl[5], 1'b1);

    // in_valid held high with changing data through SORT and DRAIN.
    feed(tbl[0].in_v, NV, 1'b1);
    wait_sort(1'b1);
    drain(tbl[0].exp_v, NV, 1'b0, 1'b1);
    run_batch(tbl[4], 1'b0);

    // Reset after four accepts.
    feed(tbl[1].in_v, 4, 1'b0);
    reset_pulse("rst_mid_load");
    run_batch(tbl[0], 1'b0);

    // Reset in the middle of sorting.
    feed(tbl[0].in_v, NV, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset_pulse("rst_mid_sort");
    run_batch(tbl[2], 1'b0);

    // Reset part way through draining.
    feed(tbl[5].in_v, NV, 1'b0);
    wait_sort(1'b0);
    drain(tbl[5].exp_v, 3, 1'b0, 1'b0);
    reset_pulse("rst_mid_drain");
    run_batch(tbl[5], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
